// File: rtl/phase_sequencer_if.sv
// Control/handshake bundle between phase_sequencer and the LEGv8 datapath stages.
// The sequencer takes the master view; control inputs and datapath logic take the slave view.
interface phase_sequencer_if #(
  parameter int WORD = 64
);
  logic            start;
  logic            halt_req;
  logic            imem_ready;
  logic            dmem_ready;
  logic            uncond_branch;
  logic            branch;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;

  logic            fetch_en;
  logic            read_en;
  logic            exec_en;
  logic            mem_rd_strobe;
  logic            mem_wr_strobe;
  logic            wb_en;
  logic            pc_write;
  logic [2:0]      phase;
  logic            busy;
  logic            error;
  logic [WORD-1:0] cycle_count;
  logic [WORD-1:0] instr_count;

  modport master (
    input  start, halt_req, imem_ready, dmem_ready,
           uncond_branch, branch, mem_read, mem_write, reg_write,
    output fetch_en, read_en, exec_en, mem_rd_strobe, mem_wr_strobe,
           wb_en, pc_write, phase, busy, error, cycle_count, instr_count
  );

  modport slave (
    output start, halt_req, imem_ready, dmem_ready,
           uncond_branch, branch, mem_read, mem_write, reg_write,
    input  fetch_en, read_en, exec_en, mem_rd_strobe, mem_wr_strobe,
           wb_en, pc_write, phase, busy, error, cycle_count, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-cycle LEGv8 phase sequencer: one-cycle stage enables, class-based phase skipping, ready stalls.
// Defining PHASE_PERF_CNT_EN builds the busy-cycle and retired-instruction counters.
module phase_sequencer #(
  parameter int WORD      = 64,
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd7
  } state_e;

  typedef struct packed {
    logic uncond_branch;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ctrl_t;

  state_e               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic                 halt_pending_q, halt_pending_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 retire;
  logic                 stall;
  logic                 busy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ctrl_q         <= '0;
      halt_pending_q <= 1'b0;
      wait_q         <= '0;
    end else begin
      state_q        <= state_d;
      ctrl_q         <= ctrl_d;
      halt_pending_q <= halt_pending_d;
      wait_q         <= wait_d;
    end
  end

  // NOTE: every always_comb target is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    retire  = 1'b0;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.halt_req) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ready) state_d = S_DECODE;
        else                stall   = 1'b1;
      end
      S_DECODE: begin
        ctrl_d = '{uncond_branch: bus.uncond_branch, branch: bus.branch,
                   mem_read: bus.mem_read, mem_write: bus.mem_write,
                   reg_write: bus.reg_write};
        if (bus.mem_read && bus.mem_write) state_d = S_ERROR;
        else                               state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (ctrl_q.mem_read || ctrl_q.mem_write) state_d = S_MEMORY;
        else if (ctrl_q.reg_write)               state_d = S_WRITEBACK;
        else                                     retire  = 1'b1;
      end
      S_MEMORY: begin
        if (!bus.dmem_ready)    stall   = 1'b1;
        else if (ctrl_q.mem_read) state_d = S_WRITEBACK;
        else                      retire  = 1'b1;
      end
      S_WRITEBACK: retire  = 1'b1;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase

    // The TIMEOUT-th consecutive not-ready cycle is the last one before ERROR.
    wait_d = '0;
    if (stall) begin
      wait_d = wait_q + TIMEOUT_W'(1);
      if (wait_d == TIMEOUT_W'(TIMEOUT)) begin
        state_d = S_ERROR;
        wait_d  = '0;
      end
    end

    // A halt request seen in the retire cycle still stops after that instruction.
    halt_pending_d = halt_pending_q | ((state_q != S_IDLE) && bus.halt_req);
    if (retire) state_d = halt_pending_d ? S_IDLE : S_FETCH;
    if (state_d == S_IDLE) halt_pending_d = 1'b0;
  end

  assign busy              = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.phase         = state_q;
  assign bus.fetch_en      = (state_q == S_FETCH);
  assign bus.read_en       = (state_q == S_DECODE);
  assign bus.exec_en       = (state_q == S_EXECUTE);
  assign bus.mem_rd_strobe = (state_q == S_MEMORY) && ctrl_q.mem_read;
  assign bus.mem_wr_strobe = (state_q == S_MEMORY) && ctrl_q.mem_write;
  assign bus.wb_en         = (state_q == S_WRITEBACK);
  assign bus.pc_write      = retire;
  assign bus.busy          = busy;
  assign bus.error         = (state_q == S_ERROR);

  // Branch class bits are latched for the datapath's view but never steer the sequence.
  logic unused_ctrl;
  assign unused_ctrl = ctrl_q.branch ^ ctrl_q.uncond_branch;

`ifdef PHASE_PERF_CNT_EN
  logic [WORD-1:0] cycle_q, instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (busy)   cycle_q <= cycle_q + WORD'(1);
      if (retire) instr_q <= instr_q + WORD'(1);
    end
  end

  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;
`else
  assign bus.cycle_count = {WORD{1'b0}};
  assign bus.instr_count = {WORD{1'b0}};
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: per-cycle comparison against a phase-list model plus directed literal cases.
module tb_phase_sequencer;
  localparam int WORD    = 64;
  localparam int TIMEOUT = 15;
`ifdef PHASE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  phase_sequencer_if #(.WORD(WORD)) sif ();

  phase_sequencer #(.WORD(WORD), .TIMEOUT(TIMEOUT), .TIMEOUT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {sif.phase, sif.fetch_en, sif.read_en, sif.exec_en, sif.mem_rd_strobe,
            sif.mem_wr_strobe, sif.wb_en, sif.pc_write, sif.busy, sif.error};
  endfunction

  // Model: an instruction is a list of remaining phases; FETCH and MEMORY wait for their ready,
  // the last phase of a decoded instruction retires.
  bit              m_run, m_err, m_halt, expanded, l_rd, l_wr;
  int              plan[$];
  int              stall_run;
  logic [WORD-1:0] m_cyc, m_ins;

  task automatic model_reset();
    m_run = 0; m_err = 0; m_halt = 0; expanded = 0; l_rd = 0; l_wr = 0;
    plan.delete(); stall_run = 0; m_cyc = '0; m_ins = '0;
  endtask

  task automatic begin_instr();
    plan.delete();
    plan.push_back(1);
    plan.push_back(2);
    expanded  = 0;
    stall_run = 0;
  endtask

  initial begin : compare
    logic [11:0] exp_o;
    int head;
    bit rdy, e_pc;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      head = m_err ? 7 : (m_run ? plan[0] : 0);
      rdy  = (head == 1) ? sif.imem_ready : ((head == 4) ? sif.dmem_ready : 1'b1);
      e_pc = m_run && expanded && (plan.size() == 1) && rdy;
      exp_o = {3'(head), head == 1, head == 2, head == 3, (head == 4) && l_rd,
               (head == 4) && l_wr, head == 5, e_pc, m_run, m_err};
      check("outputs", outs(), exp_o);
      check("cycle_count", sif.cycle_count, m_cyc);
      check("instr_count", sif.instr_count, m_ins);
      if (!reset) begin
        if (PERF) begin
          if (m_run) m_cyc = m_cyc + 1;
          if (e_pc)  m_ins = m_ins + 1;
        end
        if ((m_run || m_err) && sif.halt_req) m_halt = 1;
        if (m_err) begin
        end else if (!m_run) begin
          if (sif.start && !sif.halt_req) begin
            m_run = 1;
            begin_instr();
          end
        end else if (!rdy) begin
          stall_run++;
          if (stall_run == TIMEOUT) begin
            m_run = 0; m_err = 1;
          end
        end else begin
          stall_run = 0;
          void'(plan.pop_front());
          if (head == 2) begin
            l_rd = sif.mem_read; l_wr = sif.mem_write; expanded = 1;
            if (l_rd && l_wr) begin
              m_run = 0; m_err = 1;
            end else begin
              plan.push_back(3);
              if (l_rd || l_wr) plan.push_back(4);
              if (l_rd || (!l_wr && sif.reg_write)) plan.push_back(5);
            end
          end else if (plan.size() == 0) begin
            if (m_halt) begin
              m_run = 0; m_halt = 0;
            end else begin
              begin_instr();
            end
          end
        end
      end
    end
  end

  typedef struct {
    string       name;
    bit          rd, wr, rw, br, ub;
    int          stalls;
    logic [31:0] seq;
    int          cyc, nrd, nwr, wb_at, pc_at;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sif.start = 0; sif.halt_req = 0; sif.imem_ready = 0; sif.dmem_ready = 0;
    sif.uncond_branch = 0; sif.branch = 0; sif.mem_read = 0; sif.mem_write = 0; sif.reg_write = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // From IDLE: issue one instruction, raise halt in DECODE, record the phase trace.
  task automatic run_vec(input vec_t v);
    logic [31:0] seq;
    int n_cyc, n_rd, n_wr, wb_at, pc_at, mem_seen;
    clear_inputs();
    sif.imem_ready = 1; sif.dmem_ready = 1;
    sif.mem_read = v.rd; sif.mem_write = v.wr; sif.reg_write = v.rw;
    sif.branch = v.br; sif.uncond_branch = v.ub;
    sif.start = 1;
    tick();
    sif.start = 0;
    seq = '0; n_cyc = 0; n_rd = 0; n_wr = 0; wb_at = 0; pc_at = 0; mem_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (sif.phase == 3'd0) break;
      if (sif.phase == 3'd2) sif.halt_req = 1;
      if (sif.phase == 3'd4) begin
        sif.dmem_ready = (mem_seen >= v.stalls);
        mem_seen++;
      end
      @(negedge clk);
      n_cyc++;
      seq = {seq[28:0], sif.phase};
      if (sif.mem_rd_strobe) n_rd++;
      if (sif.mem_wr_strobe) n_wr++;
      if (sif.wb_en)    wb_at = n_cyc;
      if (sif.pc_write) pc_at = n_cyc;
      tick();
    end
    sif.halt_req = 0;
    check({v.name, "_seq"},    seq,   v.seq);
    check({v.name, "_cycles"}, n_cyc, v.cyc);
    check({v.name, "_rd"},     n_rd,  v.nrd);
    check({v.name, "_wr"},     n_wr,  v.nwr);
    check({v.name, "_wb_at"},  wb_at, v.wb_at);
    check({v.name, "_pc_at"},  pc_at, v.pc_at);
    @(negedge clk);
    check({v.name, "_idle"}, {sif.phase, sif.busy}, 0);
    tick();
  endtask

  initial begin : stimulus
    int n, s;
    tbl[0] = '{"add",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'o1235,     4, 0, 0, 4, 4};
    tbl[1] = '{"ldur", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'o12344445, 8, 4, 0, 8, 8};
    tbl[2] = '{"stur", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'o1234,     4, 0, 1, 0, 4};
    tbl[3] = '{"stur_rw_stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 32'o123444, 6, 0, 3, 0, 6};
    tbl[4] = '{"cbz",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'o123,      3, 0, 0, 0, 3};
    tbl[5] = '{"b",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'o123,      3, 0, 0, 0, 3};

    clear_inputs();
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    check("reset_counters", sif.cycle_count | sif.instr_count, 0);
    tick();
    reset = 0;

    for (int k = 0; k < 3; k++) run_vec(tbl[0]);
    check("perf_instr_3add", sif.instr_count, PERF ? 3 : 0);
    check("perf_cycle_3add", sif.cycle_count, PERF ? 12 : 0);
    for (int k = 1; k < 6; k++) run_vec(tbl[k]);

    do_reset();
    sif.start = 1;
    tick();
    sif.start = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (sif.error) break;
      @(negedge clk);
      if (sif.phase == 3'd1) n++;
      tick();
    end
    check("timeout_fetch_cycles", n, TIMEOUT);
    @(negedge clk);
    check("timeout_state", {sif.phase, sif.busy, sif.error}, {3'd7, 1'b0, 1'b1});
    tick();
    sif.start = 1; sif.imem_ready = 1;
    repeat (4) tick();
    @(negedge clk);
    check("error_sticky", sif.phase, 3'd7);
    tick();

    do_reset();
    sif.imem_ready = 1; sif.dmem_ready = 1; sif.mem_read = 1; sif.mem_write = 1; sif.start = 1;
    tick();
    sif.start = 0;
    n = 0; s = 0;
    for (int i = 0; i < 10; i++) begin
      if (sif.error) break;
      @(negedge clk);
      n++;
      if (sif.mem_rd_strobe || sif.mem_wr_strobe) s++;
      tick();
    end
    check("rdwr_cycles", n, 2);
    check("rdwr_strobes", s, 0);
    check("rdwr_phase", sif.phase, 3'd7);

    do_reset();
    sif.imem_ready = 1; sif.mem_read = 1; sif.reg_write = 1; sif.start = 1;
    tick();
    sif.start = 0;
    for (int i = 0; i < 10; i++) begin
      if (sif.phase == 3'd4) break;
      tick();
    end
    @(negedge clk);
    check("mid_mem_strobe", sif.mem_rd_strobe, 1);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("mid_mem_reset_outputs", outs(), 0);
    check("mid_mem_reset_counters", sif.cycle_count | sif.instr_count, 0);
    tick();
    reset = 0;
    clear_inputs();

    for (int c = 0; c < 4000; c++) begin
      if (sif.error || ($urandom_range(0, 299) == 0)) begin
        reset = 1;
        tick();
        reset = 0;
      end
      sif.start         = ($urandom_range(0, 3) != 0);
      sif.halt_req      = ($urandom_range(0, 19) == 0);
      sif.imem_ready    = ($urandom_range(0, 3) != 0);
      sif.dmem_ready    = ($urandom_range(0, 2) != 0);
      sif.uncond_branch = 1'($urandom_range(0, 1));
      sif.branch        = 1'($urandom_range(0, 1));
      sif.mem_read      = 1'($urandom_range(0, 1));
      sif.mem_write     = 1'($urandom_range(0, 1));
      sif.reg_write     = 1'($urandom_range(0, 1));
      if (sif.mem_read && sif.mem_write && ($urandom_range(0, 7) != 0)) sif.mem_write = 0;
      if ((c % 600) >= 300 && (c % 600) < 330) begin
        sif.imem_ready = 0;
        sif.dmem_ready = 0;
      end
      tick();
    end

    clear_inputs();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    repeat (100000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
